// File: rtl/spiker_writer.sv
// Return path of the spiker adapter: accumulates per-neuron spike counts over a run,
// picks the winning neuron with a sequential argmax and strobes the results out.
module spiker_writer #(
  parameter int N_OUT     = 10,
  parameter int CNT_WIDTH = 8,
  parameter int N_STEPS   = 25,
  parameter int IDX_WIDTH = $clog2(N_OUT)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       out_valid_i,
  input  logic [N_OUT-1:0]           out_spikes_i,
  output logic                       out_ready_o,
  output logic [N_OUT*CNT_WIDTH-1:0] counts_o,
  output logic                       counts_de_o,
  output logic [IDX_WIDTH-1:0]       winner_o,
  output logic                       winner_de_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o
);

  localparam int STEP_W = $clog2(N_STEPS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(N_STEPS - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, WRITE} state_e;

  state_e                 state_q, state_d;
  logic                   start_q, start_pulse, beat, scan_last, scan_gt, run_start;
  logic [CNT_WIDTH-1:0]   cnt_q [N_OUT];
  logic [STEP_W-1:0]      step_q;
  logic [IDX_WIDTH-1:0]   scan_q, best_idx_q, winner_q;
  logic [CNT_WIDTH-1:0]   best_val_q;
  logic                   done_q, overflow_q;

  assign start_pulse = start_i & ~start_q;
  assign run_start   = (state_q == IDLE) & start_pulse;
  assign beat        = (state_q == ACCUM) & out_valid_i;
  assign scan_last   = (scan_q == LAST_IDX);
  assign scan_gt     = cnt_q[scan_q] > best_val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_pulse) state_d = ACCUM;
      ACCUM:   if (beat && step_q == LAST_STEP) state_d = ARGMAX;
      ARGMAX:  if (scan_last) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating counters; an increment attempted at full scale flags overflow instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      step_q     <= '0;
      overflow_q <= 1'b0;
    end else if (run_start) begin
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      step_q     <= '0;
      overflow_q <= 1'b0;
    end else if (beat) begin
      step_q <= step_q + 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
        if (out_spikes_i[i]) begin
          if (cnt_q[i] == CNT_MAX) overflow_q <= 1'b1;
          else                     cnt_q[i]   <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // One neuron per cycle; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      winner_q   <= '0;
    end else if (state_q == ACCUM) begin
      scan_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else if (state_q == ARGMAX) begin
      scan_q <= scan_q + 1'b1;
      if (scan_gt) begin
        best_val_q <= cnt_q[scan_q];
        best_idx_q <= scan_q;
      end
      if (scan_last) winner_q <= scan_gt ? scan_q : best_idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                done_q <= 1'b0;
    else if (run_start)         done_q <= 1'b0;
    else if (state_q == WRITE)  done_q <= 1'b1;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_pack
    assign counts_o[(g+1)*CNT_WIDTH-1 -: CNT_WIDTH] = cnt_q[g];
  end

  assign out_ready_o = (state_q == ACCUM);
  assign busy_o      = (state_q != IDLE);
  assign counts_de_o = (state_q == WRITE);
  assign winner_de_o = (state_q == WRITE);
  assign winner_o    = winner_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_spiker_writer.sv
// Randomized scoreboard bench for spiker_writer: two instances (8-bit and 4-bit
// counters) share stimulus and are checked against a count-based reference model.
module tb_spiker_writer;

  localparam int N_OUT   = 10;
  localparam int N_STEPS = 25;
  localparam int WA      = 8;
  localparam int WB      = 4;
  localparam int IDXW    = $clog2(N_OUT);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0;
  logic [N_OUT-1:0] spikes = '0;

  logic readyA, deA, wdeA, busyA, doneA, ovA;
  logic readyB, deB, wdeB, busyB, doneB, ovB;
  logic [N_OUT*WA-1:0] countsA;
  logic [N_OUT*WB-1:0] countsB;
  logic [IDXW-1:0] winA, winB;

  always #5 clk = ~clk;

  spiker_writer #(.N_OUT(N_OUT), .CNT_WIDTH(WA), .N_STEPS(N_STEPS)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .out_valid_i(valid),
    .out_spikes_i(spikes), .out_ready_o(readyA), .counts_o(countsA),
    .counts_de_o(deA), .winner_o(winA), .winner_de_o(wdeA), .busy_o(busyA),
    .done_o(doneA), .overflow_o(ovA));

  spiker_writer #(.N_OUT(N_OUT), .CNT_WIDTH(WB), .N_STEPS(N_STEPS)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .out_valid_i(valid),
    .out_spikes_i(spikes), .out_ready_o(readyB), .counts_o(countsB),
    .counts_de_o(deB), .winner_o(winB), .winner_de_o(wdeB), .busy_o(busyB),
    .done_o(doneB), .overflow_o(ovB));

  typedef struct {
    logic [N_OUT*WA-1:0] cA;
    logic [N_OUT*WB-1:0] cB;
    logic [IDXW-1:0]     wA;
    logic [IDXW-1:0]     wB;
    logic                oA;
    logic                oB;
    int                  lastCyc;
  } exp_t;

  exp_t sbQ[$];
  int   modelCnt[N_OUT];
  int   cyc = 0;
  int   lastBeatCyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [127:0] act,
                                      input logic [127:0] expv);
    nChecks++;
    if (act === expv) nPass++;
    else $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, expv, cyc);
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < N_OUT; i++) modelCnt[i] = 0;
  endfunction

  // Reference: raw spike totals clamped to full scale; winner = first maximum.
  function automatic void satModel(input int w, output logic [127:0] pk,
                                   output int win, output logic ov);
    int maxv, best, s;
    maxv = (1 << w) - 1;
    best = -1;
    pk = '0;
    win = 0;
    ov = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      s = (modelCnt[i] > maxv) ? maxv : modelCnt[i];
      if (modelCnt[i] > maxv) ov = 1'b1;
      pk = pk | (128'(s) << (i * w));
      if (s > best) begin
        best = s;
        win = i;
      end
    end
  endfunction

  function automatic logic [N_OUT-1:0] spikeVec(input int mode, input int b);
    logic [N_OUT-1:0] v;
    v = '0;
    case (mode)
      0: begin v[3] = 1'b1; if (b < 10) v[7] = 1'b1; end
      1: begin v[2] = 1'b1; v[5] = 1'b1; end
      2: v[0] = 1'b1;
      default: v = N_OUT'($urandom);
    endcase
    return v;
  endfunction

  task automatic pushExpect();
    exp_t e;
    logic [127:0] pk;
    int win;
    logic ov;
    satModel(WA, pk, win, ov);
    e.cA = pk[N_OUT*WA-1:0];
    e.wA = IDXW'(win);
    e.oA = ov;
    satModel(WB, pk, win, ov);
    e.cB = pk[N_OUT*WB-1:0];
    e.wB = IDXW'(win);
    e.oB = ov;
    e.lastCyc = lastBeatCyc;
    sbQ.push_back(e);
  endtask

  // gapMode: 0 = valid every cycle, 1 = toggling, 2 = random. glitchIter drops
  // start for two iterations and raises it again (a pulse during ACCUM).
  task automatic applyStimulus(input int mode, input int gapMode, input int nBeats,
                               input int glitchIter);
    int beats, iter;
    logic acc;
    beats = 0;
    iter = 0;
    while (beats < nBeats && iter < 400) begin
      @(negedge clk);
      if (iter == glitchIter) start = 1'b0;
      if (iter == glitchIter + 2) start = 1'b1;
      case (gapMode)
        0: valid = 1'b1;
        1: valid = (iter % 2 == 0);
        default: valid = ($urandom_range(0, 2) != 0);
      endcase
      spikes = spikeVec(mode, beats);
      acc = valid && readyA;
      if (acc) lastBeatCyc = cyc + 1;
      @(posedge clk);
      if (acc) begin
        for (int i = 0; i < N_OUT; i++) modelCnt[i] += int'(spikes[i]);
        beats++;
      end
      iter++;
    end
    if (beats < nBeats) checkOutput("beat_budget", beats, nBeats);
    if (nBeats == N_STEPS) pushExpect();
    @(negedge clk);
    valid = 1'b0;
    if (nBeats == N_STEPS) begin
      checkOutput("ready_after_last_A", readyA, 0);
      checkOutput("ready_after_last_B", readyB, 0);
      checkOutput("busy_after_last", busyA, 1);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    modelClear();
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_cleared", doneA, 0);
    checkOutput("busy_run", busyA, 1);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!doneA && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", doneA, 1);
    checkOutput("sb_drained", sbQ.size(), 0);
  endtask

  // Monitor: pops an expectation whenever the write strobes appear.
  initial begin
    exp_t e;
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (deA || deB) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_strobe", deA | deB, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("countsA", countsA, e.cA);
          checkOutput("countsB", countsB, e.cB);
          checkOutput("winnerA", winA, e.wA);
          checkOutput("winnerB", winB, e.wB);
          checkOutput("overflowA", ovA, e.oA);
          checkOutput("overflowB", ovB, e.oB);
          checkOutput("strobesA", {deA, wdeA}, 2'b11);
          checkOutput("strobesB", {deB, wdeB}, 2'b11);
          checkOutput("latency", cyc - e.lastCyc, N_OUT);
          checkOutput("done_before_write", doneA, 0);
          pend = 1'b1;
        end
      end else if (pend) begin
        checkOutput("doneA_after_write", doneA, 1);
        checkOutput("doneB_after_write", doneB, 1);
        checkOutput("busy_after_write", busyA, 0);
        pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelClear();
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", readyA, 0);
    checkOutput("reset_busy", busyA, 0);
    checkOutput("reset_done", doneA, 0);
    checkOutput("reset_counts", countsA, 0);
    rst_n = 1'b1;

    $display("[TB] idle with valid high, no start");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      valid = 1'b1;
      spikes = N_OUT'($urandom);
      checkOutput("idle_ready", {readyA, readyB}, 0);
      checkOutput("idle_strobe", {deA, wdeA}, 0);
      checkOutput("idle_done_busy", {doneA, busyA}, 0);
    end
    valid = 1'b0;

    $display("[TB] neuron 3 every beat, neuron 7 on ten beats");
    pulseStart();
    applyStimulus(0, 0, N_STEPS, -10);
    waitDone();

    $display("[TB] tie between neurons 2 and 5");
    pulseStart();
    applyStimulus(1, 0, N_STEPS, -10);
    waitDone();

    $display("[TB] gapped beats, neuron 0 saturates narrow counters");
    pulseStart();
    applyStimulus(2, 1, N_STEPS, -10);
    waitDone();

    $display("[TB] held start and ignored pulse during a run");
    @(negedge clk);
    start = 1'b1;
    modelClear();
    applyStimulus(3, 0, N_STEPS, 5);
    waitDone();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("held_no_rerun", {busyA, doneA}, 2'b01);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    modelClear();
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_done_clear", doneA, 0);
    checkOutput("restart_busy", busyA, 1);
    checkOutput("restart_countsA", countsA, 0);
    checkOutput("restart_countsB", countsB, 0);
    checkOutput("restart_overflow", ovB, 0);
    applyStimulus(3, 2, N_STEPS, -10);
    waitDone();

    $display("[TB] reset after beat 12");
    pulseStart();
    applyStimulus(3, 0, 12, -10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ctrl", {readyA, busyA, deA, wdeA, doneA}, 0);
    checkOutput("rst_countsA", countsA, 0);
    checkOutput("rst_countsB", countsB, 0);
    checkOutput("rst_winner", {winA, winB}, 0);
    checkOutput("rst_overflow", {ovA, ovB}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelClear();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", {doneA, busyA, deA}, 0);
    end
    pulseStart();
    applyStimulus(3, 2, N_STEPS, -10);
    waitDone();

    $display("[TB] random runs");
    for (int r = 0; r < 4; r++) begin
      pulseStart();
      applyStimulus(3, 2, N_STEPS, -10);
      waitDone();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
